// File: rtl/exec_sched.sv
// ---------------------------------------------------------------------------
// exec_sched -- Execute-stage scheduler for the multi-cycle FPU and matmul
// units. It launches one unit per instruction, stalls Execute and the earlier
// stages while that unit runs, and steers the result mux during the single
// DONE cycle. A per-run watchdog forces completion if the unit never reports
// done, and it raises a sticky timeout flag when that happens.
//
// Ports:
//   clk           in   clock, rising edge
//   reset         in   asynchronous, active-low reset
//   FPUStartE     in   FPU instruction in Execute
//   FPUControlE   in   [2:0] FPU operation code
//   MatmulStartE  in   matmul instruction in Execute
//   FPUDone       in   FPU completion pulse
//   MatmulDone    in   matmul completion pulse
//   TimeoutClr    in   clears ExecTimeout
//   FPUGo         out  one-cycle FPU launch pulse (registered)
//   FPUOp         out  [2:0] op code latched at the FPU launch
//   MatmulGo      out  one-cycle matmul launch pulse (registered)
//   StallE        out  stall Execute and earlier stages (combinational)
//   MatmulBusy    out  matmul in flight
//   ResSelE       out  [1:0] result select: 00 ALU, 01 FPU, 10 matmul
//   ExecTimeout   out  sticky: a unit failed to complete in time
// ---------------------------------------------------------------------------
module exec_sched #(
  parameter int TIMEOUT_CYCLES = 256  // legal range 2..1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FPUStartE,
  input  logic [2:0] FPUControlE,
  input  logic       MatmulStartE,
  input  logic       FPUDone,
  input  logic       MatmulDone,
  input  logic       TimeoutClr,
  output logic       FPUGo,
  output logic [2:0] FPUOp,
  output logic       MatmulGo,
  output logic       StallE,
  output logic       MatmulBusy,
  output logic [1:0] ResSelE,
  output logic       ExecTimeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FPU_RUN = 2'd1,
    MM_RUN  = 2'd2,
    DONE    = 2'd3
  } stateT;

  localparam logic [9:0] LAST_CNT = 10'(TIMEOUT_CYCLES - 1);

  stateT      stateReg;
  logic [9:0] cycleCnt;

  logic running;
  logic unitDone;
  logic timeoutHit;

  assign running = (stateReg == FPU_RUN) || (stateReg == MM_RUN);

  // Only the done pulse of the unit that is actually running counts.
  assign unitDone = ((stateReg == FPU_RUN) && FPUDone) ||
                    ((stateReg == MM_RUN) && MatmulDone);

  // A done pulse arriving in the last allowed cycle still counts as a
  // normal completion, not a timeout.
  assign timeoutHit = running && !unitDone && (cycleCnt == LAST_CNT);

  // Combinational so the pipeline freezes in the same cycle the start is
  // seen; DONE releases the stall so the result can retire.
  assign StallE = ((stateReg == IDLE) && (FPUStartE || MatmulStartE)) || running;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg    <= IDLE;
      cycleCnt    <= '0;
      FPUGo       <= 1'b0;
      FPUOp       <= 3'b000;
      MatmulGo    <= 1'b0;
      MatmulBusy  <= 1'b0;
      ResSelE     <= 2'b00;
      ExecTimeout <= 1'b0;
    end else begin
      FPUGo    <= 1'b0;
      MatmulGo <= 1'b0;

      case (stateReg)
        IDLE: begin
          // FPU has priority; a simultaneous matmul request is dropped.
          if (FPUStartE) begin
            stateReg <= FPU_RUN;
            FPUOp    <= FPUControlE;
            FPUGo    <= 1'b1;
            cycleCnt <= '0;
          end else if (MatmulStartE) begin
            stateReg   <= MM_RUN;
            MatmulGo   <= 1'b1;
            MatmulBusy <= 1'b1;
            cycleCnt   <= '0;
          end
        end

        FPU_RUN, MM_RUN: begin
          if (unitDone || timeoutHit) begin
            stateReg   <= DONE;
            MatmulBusy <= 1'b0;
            ResSelE    <= (stateReg == FPU_RUN) ? 2'b01 : 2'b10;
          end else begin
            cycleCnt <= cycleCnt + 10'd1;
          end
        end

        DONE: begin
          // The finishing instruction is still in Execute this cycle, so its
          // start bits are deliberately not looked at here.
          stateReg <= IDLE;
          ResSelE  <= 2'b00;
        end

        default: begin
          stateReg <= IDLE;
        end
      endcase

      // Set has priority over clear.
      if (timeoutHit) begin
        ExecTimeout <= 1'b1;
      end else if (TimeoutClr) begin
        ExecTimeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_exec_sched.sv
// ---------------------------------------------------------------------------
// tb_exec_sched -- self-checking bench for exec_sched (TIMEOUT_CYCLES = 4).
// Each instruction is described by which unit(s) request, the op code and the
// cycle in which the running unit reports done. From that the bench works
// out the run length, the DONE cycle and whether the watchdog fires, and it
// predicts every output cycle by cycle. Inputs change 1 ns after the rising
// edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_exec_sched;

  localparam int T = 4;

  logic       clk;
  logic       reset;
  logic       FPUStartE;
  logic [2:0] FPUControlE;
  logic       MatmulStartE;
  logic       FPUDone;
  logic       MatmulDone;
  logic       TimeoutClr;
  logic       FPUGo;
  logic [2:0] FPUOp;
  logic       MatmulGo;
  logic       StallE;
  logic       MatmulBusy;
  logic [1:0] ResSelE;
  logic       ExecTimeout;

  int checks = 0;
  int errors = 0;

  // Reference state kept by the bench.
  logic [2:0] expOp = 3'b000;
  logic       expTo = 1'b0;

  exec_sched #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .FPUStartE   (FPUStartE),
    .FPUControlE (FPUControlE),
    .MatmulStartE(MatmulStartE),
    .FPUDone     (FPUDone),
    .MatmulDone  (MatmulDone),
    .TimeoutClr  (TimeoutClr),
    .FPUGo       (FPUGo),
    .FPUOp       (FPUOp),
    .MatmulGo    (MatmulGo),
    .StallE      (StallE),
    .MatmulBusy  (MatmulBusy),
    .ResSelE     (ResSelE),
    .ExecTimeout (ExecTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the expected vector for this cycle.
  task automatic chkAll(input string tag, input logic stall, input logic fgo,
                        input logic mgo, input logic busy, input logic [1:0] rsel);
    chk({tag, ".StallE"},      {7'd0, StallE},      {7'd0, stall});
    chk({tag, ".FPUGo"},       {7'd0, FPUGo},       {7'd0, fgo});
    chk({tag, ".MatmulGo"},    {7'd0, MatmulGo},    {7'd0, mgo});
    chk({tag, ".MatmulBusy"},  {7'd0, MatmulBusy},  {7'd0, busy});
    chk({tag, ".ResSelE"},     {6'd0, ResSelE},     {6'd0, rsel});
    chk({tag, ".FPUOp"},       {5'd0, FPUOp},       {5'd0, expOp});
    chk({tag, ".ExecTimeout"}, {7'd0, ExecTimeout}, {7'd0, expTo});
  endtask

  // One instruction, from the cycle its start is seen (cycle 0) to the first
  // IDLE cycle after DONE. Starts stay high through DONE, as they would while
  // the instruction sits in Execute. k = cycle the running unit reports done
  // (k > T means it never does in time). clrAt = cycle to pulse TimeoutClr.
  // noise adds spurious done pulses, op changes and random clears.
  task automatic runTxn(input string name, input bit fpu, input bit mm,
                        input logic [2:0] op, input int k, input int clrAt,
                        input bit noise);
    bit fpuAct, mmAct, toHit;
    int runLen, doneCyc;
    logic stall, fgo, mgo, busy;
    logic [1:0] rsel;
    fpuAct  = fpu;
    mmAct   = mm && !fpu;
    toHit   = (k > T);
    runLen  = toHit ? T : k;
    doneCyc = runLen + 1;
    for (int c = 0; c <= doneCyc + 1; c++) begin
      FPUStartE    = (c <= doneCyc) ? fpu : 1'b0;
      MatmulStartE = (c <= doneCyc) ? mm  : 1'b0;
      FPUControlE  = (c == 0) ? op : (noise ? 3'($urandom) : op);
      FPUDone      = fpuAct ? (c == k) : (noise && $urandom_range(0, 1) == 1);
      MatmulDone   = mmAct  ? (c == k) : (noise && $urandom_range(0, 1) == 1);
      // Outside RUN any done pulse should be ignored, even the active unit's.
      if (noise && (c == 0 || c >= doneCyc)) begin
        FPUDone    = FPUDone    | ($urandom_range(0, 1) == 1);
        MatmulDone = MatmulDone | ($urandom_range(0, 1) == 1);
      end
      TimeoutClr = (c == clrAt) || (noise && $urandom_range(0, 7) == 0);

      @(negedge clk);
      stall = (c == 0) || (c >= 1 && c <= runLen);
      fgo   = fpuAct && (c == 1);
      mgo   = mmAct && (c == 1);
      busy  = mmAct && (c >= 1 && c <= runLen);
      rsel  = (c == doneCyc) ? (fpuAct ? 2'b01 : 2'b10) : 2'b00;
      chkAll($sformatf("%s.c%0d", name, c), stall, fgo, mgo, busy, rsel);
      $display("%s cycle %0d: StallE=%b FPUGo=%b MatmulGo=%b Busy=%b ResSelE=%b FPUOp=%b ExecTimeout=%b",
               name, c, StallE, FPUGo, MatmulGo, MatmulBusy, ResSelE, FPUOp, ExecTimeout);

      // Reference update for the edge that ends this cycle.
      if (c == 0 && fpuAct) expOp = op;
      if (toHit && c == runLen) expTo = 1'b1;
      else if (TimeoutClr)      expTo = 1'b0;

      @(posedge clk);
      #1;
    end
  endtask

  task automatic idleInputs();
    FPUStartE = 0; MatmulStartE = 0; FPUControlE = 0;
    FPUDone = 0; MatmulDone = 0; TimeoutClr = 0;
  endtask

  initial begin
    reset = 1'b0;
    idleInputs();

    // Held in reset: outputs zero, StallE still follows the start inputs.
    @(posedge clk); #1;
    FPUStartE = 1'b1;
    @(negedge clk);
    chkAll("rst.start", 1'b1, 0, 0, 0, 2'b00);
    @(posedge clk); #1;
    FPUStartE = 1'b0;
    @(negedge clk);
    chkAll("rst.idle", 1'b0, 0, 0, 0, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed cases.
    runTxn("fpu_op101_k4", 1, 0, 3'b101, 4, -1, 0);
    runTxn("mm_k1",        0, 1, 3'b010, 1, -1, 0);
    runTxn("both_k2",      1, 1, 3'b011, 2, -1, 0);
    runTxn("fpu_timeout",  1, 0, 3'b110, T + 3, -1, 0);
    runTxn("mm_sticky",    0, 1, 3'b000, 2, -1, 0);
    runTxn("mm_clr_c1",    0, 1, 3'b000, 2, 1, 0);
    // Timeout and clear in the same cycle: the set must survive.
    runTxn("mm_to_setclr", 0, 1, 3'b000, T + 1, T, 0);
    runTxn("fpu_clr_c0",   1, 0, 3'b001, T, 0, 0);

    // Abort mid-MM_RUN with reset: no DONE, everything back to zero.
    idleInputs();
    MatmulStartE = 1'b1;
    @(posedge clk); #1;           // cycle 1, MM_RUN
    @(posedge clk); #1;           // cycle 2
    @(posedge clk); #1;           // cycle 3
    @(negedge clk);
    chk("abort.pre.Busy", {7'd0, MatmulBusy}, 8'd1);
    @(posedge clk); #1;           // cycle 4: drop reset mid-cycle
    reset = 1'b0;
    #1;
    chk("abort.Busy.now", {7'd0, MatmulBusy}, 8'd0);
    expOp = 3'b000;
    expTo = 1'b0;
    @(negedge clk);
    chkAll("abort.inrst", 1'b1, 0, 0, 0, 2'b00);
    @(posedge clk); #1;
    MatmulStartE = 1'b0;
    @(negedge clk);
    chkAll("abort.inrst2", 1'b0, 0, 0, 0, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    MatmulDone = 1'b1;            // spurious done in IDLE
    @(negedge clk);
    chkAll("abort.rel", 1'b0, 0, 0, 0, 2'b00);
    @(posedge clk); #1;
    MatmulDone = 1'b0;
    @(negedge clk);
    chkAll("abort.noDone", 1'b0, 0, 0, 0, 2'b00);
    @(posedge clk); #1;

    // Randomised instructions with noise on the unused inputs.
    for (int i = 0; i < 40; i++) begin
      bit f, m;
      int sel;
      sel = $urandom_range(0, 2);
      f = (sel != 1);
      m = (sel != 0);
      runTxn($sformatf("rnd%0d", i), f, m, 3'($urandom), $urandom_range(1, T + 2), -1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
